// File: rtl/miss_mem_arbiter_if.sv
// Memory-side request/response channel between the miss arbiter and the main-memory model.
// The arbiter is the master of the valid/ready request and the sink of the response pulse.
interface miss_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 128
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_we;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_we,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_we,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/miss_mem_arbiter.sv
// Buffers one icache and one dcache miss, arbitrates between them, issues the winner to memory
// and returns a one-cycle tagged response (data or bus error) to the requesting cache.
module miss_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned MEM_LINES      = 320,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           dcache_req_valid_miss,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] dcache_req_info_miss,
    input  logic                           icache_req_valid_miss,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] icache_req_info_miss,
    output logic                           rsp_valid_miss,
    output logic                           rsp_cache_id,
    output logic [DATA_WIDTH-1:0]          rsp_data_miss,
    output logic                           rsp_bus_error,
    miss_mem_arbiter_if.master             mem,
    output logic                           protocol_err_o
);

    localparam int unsigned INFO_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned WE_BIT = DATA_WIDTH;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_ERROR_RSP,
        S_RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic                d_pend_q, d_pend_d;
    logic                i_pend_q, i_pend_d;
    logic [INFO_W-1:0]   d_info_q, d_info_d;
    logic [INFO_W-1:0]   i_info_q, i_info_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                perr_q, perr_d;

    logic                  arb_any;
    logic                  arb_grant;
    logic [ADDR_WIDTH-1:0] arb_addr;
    logic [INFO_W-1:0]     sel_info;
    logic                  d_free;
    logic                  i_free;

    // Grant value: 1 = dcache, 0 = icache; on a tie the cache not served last wins.
    always_comb begin
        arb_any = d_pend_q | i_pend_q;
        if (d_pend_q && i_pend_q) begin
            arb_grant = ~last_grant_q;
        end else begin
            arb_grant = d_pend_q;
        end
        arb_addr = arb_grant ? d_info_q[INFO_W-1 -: ADDR_WIDTH]
                             : i_info_q[INFO_W-1 -: ADDR_WIDTH];
        sel_info = grant_q ? d_info_q : i_info_q;
    end

    // A new pulse in the freeing RESPOND cycle reloads the entry instead of being an overrun.
    always_comb begin
        d_free   = (state_q == S_RESPOND) && grant_q;
        i_free   = (state_q == S_RESPOND) && !grant_q;
        d_pend_d = d_pend_q;
        i_pend_d = i_pend_q;
        d_info_d = d_info_q;
        i_info_d = i_info_q;
        perr_d   = perr_q;

        if (dcache_req_valid_miss) begin
            if (!d_pend_q || d_free) begin
                d_pend_d = 1'b1;
                d_info_d = dcache_req_info_miss;
            end else begin
                perr_d = 1'b1;
            end
        end else if (d_free) begin
            d_pend_d = 1'b0;
        end

        if (icache_req_valid_miss) begin
            if (!i_pend_q || i_free) begin
                i_pend_d = 1'b1;
                i_info_d = icache_req_info_miss;
            end else begin
                perr_d = 1'b1;
            end
        end else if (i_free) begin
            i_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_addr >= ADDR_WIDTH'(MEM_LINES)) begin
                        state_d = S_ERROR_RSP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem.mem_req_ready) begin
                    state_d = S_WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.mem_rsp_valid) begin
                    state_d     = S_RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_q;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = sel_info[WE_BIT] ? '0 : mem.mem_rsp_data;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_q;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            S_ERROR_RSP: begin
                state_d     = S_RESPOND;
                rsp_valid_d = 1'b1;
                rsp_id_d    = grant_q;
                rsp_err_d   = 1'b1;
                rsp_data_d  = '0;
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            d_pend_q     <= 1'b0;
            i_pend_q     <= 1'b0;
            d_info_q     <= '0;
            i_info_q     <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_pend_q     <= d_pend_d;
            i_pend_q     <= i_pend_d;
            d_info_q     <= d_info_d;
            i_info_q     <= i_info_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        mem.mem_req_valid = (state_q == S_ISSUE);
        mem.mem_req_addr  = '0;
        mem.mem_req_we    = 1'b0;
        mem.mem_req_wdata = '0;
        if (state_q == S_ISSUE) begin
            mem.mem_req_addr  = sel_info[INFO_W-1 -: ADDR_WIDTH];
            mem.mem_req_we    = sel_info[WE_BIT];
            mem.mem_req_wdata = sel_info[DATA_WIDTH-1:0];
        end
    end

    assign rsp_valid_miss = rsp_valid_q;
    assign rsp_cache_id   = rsp_id_q;
    assign rsp_data_miss  = rsp_data_q;
    assign rsp_bus_error  = rsp_err_q;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_miss_mem_arbiter.sv
// Scoreboard bench for miss_mem_arbiter: directed cache pulses, a small memory model,
// and independent monitors for the memory request channel and the cache response pulse.
module tb_miss_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 128;
    localparam int IW = AW + DW + 1;

    localparam logic [DW-1:0] D1  = {4{32'h0000_1111}};
    localparam logic [DW-1:0] D2  = {4{32'h2222_2222}};
    localparam logic [DW-1:0] D3  = {4{32'h3333_0003}};
    localparam logic [DW-1:0] D4  = {4{32'h4444_0004}};
    localparam logic [DW-1:0] D5  = {8{16'hA5A5}};
    localparam logic [DW-1:0] D6  = {4{32'h6666_0006}};
    localparam logic [DW-1:0] D7  = {4{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] D9  = {4{32'h9999_0009}};
    localparam logic [DW-1:0] D11 = {4{32'hBBBB_0011}};
    localparam logic [DW-1:0] D12 = {4{32'hCCCC_0012}};

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          dv = 1'b0;
    logic          iv = 1'b0;
    logic [IW-1:0] dinfo = '0;
    logic [IW-1:0] iinfo = '0;
    logic          rsp_valid_miss;
    logic          rsp_cache_id;
    logic [DW-1:0] rsp_data_miss;
    logic          rsp_bus_error;
    logic          protocol_err_o;

    miss_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    miss_mem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MEM_LINES     (320),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i                 (clk),
        .reset_ni              (reset_ni),
        .dcache_req_valid_miss (dv),
        .dcache_req_info_miss  (dinfo),
        .icache_req_valid_miss (iv),
        .icache_req_info_miss  (iinfo),
        .rsp_valid_miss        (rsp_valid_miss),
        .rsp_cache_id          (rsp_cache_id),
        .rsp_data_miss         (rsp_data_miss),
        .rsp_bus_error         (rsp_bus_error),
        .mem                   (mif),
        .protocol_err_o        (protocol_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    logic [DW-1:0] mem_arr [0:511];
    logic respond_en = 1'b1;
    int   rsp_delay  = 1;
    int   late_cnt   = 0;

    int rsp_cnt      = 0;
    int rsp_cyc      = 0;
    int rsp_gap      = 0;
    int acc_cyc      = 0;
    int valid_cycles = 0;
    int stall_cnt    = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        return {a, we, wd};
    endfunction

    task automatic push_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        req_t r;
        r.addr = a;
        r.we = we;
        r.wdata = wd;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input logic id, input logic err, input logic [DW-1:0] d);
        rsp_t r;
        r.id = id;
        r.err = err;
        r.data = d;
        exp_rsp.push_back(r);
    endtask

    // Pulses the selected cache inputs for one cycle; t is the cycle of the pulse.
    task automatic drive(input logic den, input logic [IW-1:0] di,
                         input logic ien, input logic [IW-1:0] ii, output int t);
        dv = den;
        dinfo = di;
        iv = ien;
        iinfo = ii;
        t = cyc;
        tick();
        dv = 1'b0;
        iv = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_arrival", rsp_cnt, target);
    endtask

    // Memory model: replies rsp_delay cycles after acceptance; late_cnt injects stray pulses.
    initial begin
        int cd = 0;
        int late_done = 0;
        logic acc;
        logic [AW-1:0] pend_addr = '0;
        mif.mem_req_ready = 1'b0;
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc = mif.mem_req_valid && mif.mem_req_ready;
            mif.mem_rsp_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mif.mem_rsp_valid = 1'b1;
                    mif.mem_rsp_data  = mem_arr[pend_addr[8:0]];
                end
            end
            if (late_done != late_cnt) begin
                late_done = late_cnt;
                mif.mem_rsp_valid = 1'b1;
                mif.mem_rsp_data  = '1;
            end
            if (acc && respond_en) begin
                cd = rsp_delay;
                pend_addr = mif.mem_req_addr;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mif.mem_req_valid) begin
                valid_cycles++;
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual_addr=%0h required=none", mif.mem_req_addr);
                end else begin
                    chk("req_addr", mif.mem_req_addr, exp_req[0].addr);
                    chk("req_we", mif.mem_req_we, exp_req[0].we);
                    chk("req_wdata", mif.mem_req_wdata, exp_req[0].wdata);
                    if (mif.mem_req_ready) begin
                        void'(exp_req.pop_front());
                        acc_cyc = cyc;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        rsp_t e;
        bit have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid_miss) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual_id=%0d required=none", rsp_cache_id);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_id", rsp_cache_id, e.id);
                    chk("rsp_err", rsp_bus_error, e.err);
                    chk("rsp_data", rsp_data_miss, e.data);
                end
                if (have_prev) rsp_gap = cyc - rsp_cyc;
                have_prev = 1'b1;
                rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int v0;
        for (int i = 0; i < 512; i++) mem_arr[i] = '0;
        mem_arr[1] = D1;  mem_arr[2] = D2;  mem_arr[3] = D3;  mem_arr[4] = D4;
        mem_arr[5] = D5;  mem_arr[6] = D6;  mem_arr[7] = D7;  mem_arr[9] = D9;
        mem_arr[11] = D11; mem_arr[12] = D12;

        tick();
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid_miss, 0);
        chk("rst_rsp_data", rsp_data_miss, 0);
        chk("rst_mem_valid", mif.mem_req_valid, 0);
        chk("rst_perr", protocol_err_o, 0);
        tick();
        reset_ni = 1'b1;
        mif.mem_req_ready = 1'b1;
        tick();

        // Simultaneous first pulses: dcache served first, then icache, 4 cycles apart.
        rsp_delay = 1;
        push_req(20'd1, 1'b0, '0);
        push_req(20'd2, 1'b0, '0);
        push_rsp(1'b1, 1'b0, D1);
        push_rsp(1'b0, 1'b0, D2);
        drive(1'b1, mk(20'd1, 1'b0, '0), 1'b1, mk(20'd2, 1'b0, '0), t);
        wait_rsp(2, 40);
        chk("b2b_gap", rsp_gap, 4);
        chk("t2_perr", protocol_err_o, 0);

        // dcache read, memory answers 3 cycles after accept.
        rsp_delay = 3;
        push_req(20'd5, 1'b0, '0);
        push_rsp(1'b1, 1'b0, D5);
        drive(1'b1, mk(20'd5, 1'b0, '0), 1'b0, '0, t);
        wait_rsp(3, 40);
        chk("t1_req_cycle", acc_cyc - t, 2);
        chk("t1_rsp_cycle", rsp_cyc - t, 6);

        // Out-of-range icache address: error response, no memory traffic.
        v0 = valid_cycles;
        push_rsp(1'b0, 1'b1, '0);
        drive(1'b0, '0, 1'b1, mk(20'd320, 1'b0, '0), t);
        wait_rsp(4, 20);
        chk("t3_rsp_cycle", rsp_cyc - t, 3);
        chk("t3_no_mem_req", valid_cycles, v0);

        // dcache write with ready held low for 5 cycles.
        rsp_delay = 1;
        mif.mem_req_ready = 1'b0;
        v0 = stall_cnt;
        push_req(20'd7, 1'b1, 128'h1234);
        push_rsp(1'b1, 1'b0, '0);
        drive(1'b1, mk(20'd7, 1'b1, 128'h1234), 1'b0, '0, t);
        repeat (6) tick();
        mif.mem_req_ready = 1'b1;
        wait_rsp(5, 30);
        chk("t4_stall_cycles", stall_cnt - v0, 5);
        chk("t4_accept_cycle", acc_cyc - t, 7);

        // No memory answer: timeout 64 cycles into WAIT_RSP, then stray pulses ignored.
        respond_en = 1'b0;
        push_req(20'd9, 1'b0, '0);
        push_rsp(1'b1, 1'b1, '0);
        drive(1'b1, mk(20'd9, 1'b0, '0), 1'b0, '0, t);
        wait_rsp(6, 120);
        chk("t5_timeout_cycle", rsp_cyc - acc_cyc, 65);
        late_cnt++;
        respond_en = 1'b1;
        tick();
        tick();
        mif.mem_req_ready = 1'b0;
        push_req(20'd3, 1'b0, '0);
        push_rsp(1'b0, 1'b0, D3);
        drive(1'b0, '0, 1'b1, mk(20'd3, 1'b0, '0), t);
        tick();
        late_cnt++;
        tick();
        mif.mem_req_ready = 1'b1;
        wait_rsp(7, 30);

        // Overrun on a pending dcache entry: sticky error, original request kept.
        mif.mem_req_ready = 1'b0;
        push_req(20'd11, 1'b0, '0);
        push_rsp(1'b1, 1'b0, D11);
        drive(1'b1, mk(20'd11, 1'b0, '0), 1'b0, '0, t);
        tick();
        drive(1'b1, mk(20'd12, 1'b0, '0), 1'b0, '0, t);
        chk("t6_perr_set", protocol_err_o, 1);
        tick();
        mif.mem_req_ready = 1'b1;
        wait_rsp(8, 30);
        v0 = valid_cycles;
        repeat (6) tick();
        chk("t6_dropped_pulse", valid_cycles, v0);
        chk("t6_perr_sticky", protocol_err_o, 1);

        // Reset in WAIT_RSP: outputs and buffers clear, no response appears.
        rsp_delay = 6;
        push_req(20'd4, 1'b0, '0);
        drive(1'b0, '0, 1'b1, mk(20'd4, 1'b0, '0), t);
        repeat (4) tick();
        reset_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_data", rsp_data_miss, 0);
        chk("mid_rst_rsp_id", rsp_cache_id, 0);
        chk("mid_rst_mem_valid", mif.mem_req_valid, 0);
        chk("mid_rst_perr", protocol_err_o, 0);
        tick();
        tick();
        reset_ni = 1'b1;
        repeat (12) tick();
        chk("mid_rst_no_rsp", rsp_cnt, 8);
        rsp_delay = 1;
        push_req(20'd6, 1'b0, '0);
        push_rsp(1'b1, 1'b0, D6);
        drive(1'b1, mk(20'd6, 1'b0, '0), 1'b0, '0, t);
        wait_rsp(9, 30);
        repeat (4) tick();
        chk("sb_req_empty", exp_req.size(), 0);
        chk("sb_rsp_empty", exp_rsp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
